bsm_operand_driver: RTL and testbench
=====================================

# bsm_operand_driver

Transmit-side front end for the bit-serial multiplier (BSM). Accepts one signed operand pair plus declared widths over a valid/ready handshake, frames the transaction with `start`, and shifts both operands LSB-first with sign extension into the BSM. It waits for `done`, then returns the 32-bit product on a second valid/ready handshake. A watchdog aborts the transaction if `done` never arrives.

## Interface
- `DW`, 32: parallel operand and product width.
- `TIMEOUT`, 64: maximum number of SHIFT cycles to wait for `done` before aborting.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: driver can accept an operand pair.
- `in_a`, `in_b` in DW: signed operands.
- `in_wa`, `in_wb` in 5: declared widths of A and B, legal range 1..31.
- `start` out 1: transaction-start pulse to the BSM.
- `WA`, `WB` out 5: latched widths to the BSM, stable for the whole transaction.
- `bitAin`, `bitBin` out 1: serial operand bits to the BSM.
- `O` in DW: signed BSM product, sampled when `done`=1.
- `done` in 1: BSM result strobe.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_o` out DW: captured product; 0 on error.
- `out_err` out 1: result is a timeout abort.
- `busy` out 1: driver is in a state other than IDLE.

## Operation
- FSM states: IDLE, START, SHIFT, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `in_a`, `in_b`, `in_wa`, `in_wb`; clear the bit index k and the watchdog; go to START.
- START (exactly 1 cycle):
  - `start`=1.
  - Drive bit 0 of both operands.
  - Go to SHIFT with k=1.
- SHIFT:
  - Drive bit k each cycle; k increments and saturates at 31.
  - On `done`=1: capture `O` into `out_o`, clear `out_err`, go to HOLD.
  - Else, when the watchdog reaches TIMEOUT: set `out_o`=0, `out_err`=1, go to HOLD.
- HOLD:
  - `out_valid`=1; `out_o` and `out_err` are held stable.
  - On `out_valid && out_ready`: go to IDLE.
- Bit rule for operand A (B is identical using WB):
  - k < WA: bit = a[k].
  - k ≥ WA: bit = a[WA-1] (sign extension).
  - WA=0 is illegal; the driver outputs 0 for every bit.
- Operand bits above WA-1 are ignored. The driver does not range-check the operand value against its declared width.
- `done` is ignored in IDLE, START and HOLD.
- `in_ready` is 1 only in IDLE and never while `rst`=1. There is no operand/result overlap.

## Timing
- Reset (synchronous; also applies mid-transaction): state returns to IDLE.
- Values in the cycle after `rst` is sampled high:
  - `start`, `bitAin`, `bitBin`, `WA`, `WB`, `out_valid`, `out_o`, `out_err`, `busy` all 0.
  - `in_ready` 0 while `rst`=1, and 1 in the first cycle after reset is released.
- Reset mid-transaction discards the pending transaction and produces no result.
- Handshake accepted at edge N:
  - `start`=1 during cycle N+1, carrying bit 0.
  - Bit k is driven during cycle N+1+k.
- `done`=1 sampled at edge M: `out_valid`=1 from cycle M+1.
- `out_valid` is held until `out_ready`. After the accepting edge, `in_ready`=1 in the next cycle.
- Minimum back-to-back spacing between `start` pulses: SHIFT length + 3 cycles.
- Watchdog: counts SHIFT cycles. If `done` is absent for TIMEOUT consecutive SHIFT cycles, HOLD is entered with the error flag set.
- `done` arriving in the same cycle the watchdog expires: `done` wins (valid product, no error).
- `bitAin`, `bitBin`, `start`, `WA`, `WB` are registered outputs with no combinational paths from inputs.

## Structure
- Package `bsm_pkg`:
  - `bsm_state_t` enum (IDLE, START, SHIFT, HOLD).
  - Localparams DW and TIMEOUT defaults.
  - Width typedef for 5-bit width fields.
- Sub-module `bsm_bit_select`: combinational sign-extending bit picker. Inputs: operand, width, index. Output: one bit. Instantiated once per operand.
- The top level holds the FSM, bit counter, watchdog and result register.

## Test plan
- A=15, WA=8, B=-7, WB=15, BSM model attached: `start` 1 cycle after the handshake; `out_o`=-105, `out_err`=0.
- A=-3 (0x...FD), WA=4, bitstream monitor: bits 1,0,1,1 followed by continuous 1s until `done`; WA=4 on the bus throughout.
- `out_ready` held 0 for 10 cycles after `out_valid`: `out_o` stable, `in_ready`=0, no new `start`; accepted on release, `in_ready`=1 next cycle.
- BSM model never asserts `done`, TIMEOUT=64: HOLD after 64 SHIFT cycles with `out_err`=1 and `out_o`=0.
- `rst` pulsed at SHIFT k=5: next cycle `busy`=0, `start`=0, `out_valid`=0, `in_ready`=0; new operands afterwards complete normally.
- 200 random legal pairs back-to-back with `out_ready`=1: every `out_o` equals A*B and `start` pulses are exactly one cycle wide.

Source files
------------

// File: rtl/bsm_pkg.sv
// bsm_pkg: shared types and defaults for the bit-serial multiplier operand driver
package bsm_pkg;
    localparam int DW = 32;
    localparam int TIMEOUT = 64;
    typedef logic [4:0] bsm_width_t;
    typedef enum logic [1:0] {IDLE, START, SHIFT, HOLD} bsm_state_t;
endpackage

// File: rtl/bsm_bit_select.sv
// bsm_bit_select: picks bit index of an operand, sign-extending past the declared width
module bsm_bit_select #(
    parameter int W = bsm_pkg::DW
) (
    input  logic [W-1:0] op,
    input  logic [4:0]   width,
    input  logic [4:0]   index,
    output logic         sel
);
    assign sel = width == 5'd0 ? 1'b0 : index < width ? op[index] : op[width - 5'd1];
endmodule

// File: rtl/bsm_operand_driver.sv
// bsm_operand_driver: frames an operand pair, shifts it LSB-first into the BSM and returns the product
module bsm_operand_driver #(
    parameter int DW = bsm_pkg::DW,
    parameter int TIMEOUT = bsm_pkg::TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [4:0]    in_wa,
    input  logic [4:0]    in_wb,
    output logic          start,
    output logic [4:0]    WA,
    output logic [4:0]    WB,
    output logic          bitAin,
    output logic          bitBin,
    input  logic [DW-1:0] O,
    input  logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_o,
    output logic          out_err,
    output logic          busy
);
    import bsm_pkg::*;
    localparam int WDW = $clog2(TIMEOUT + 1);
    bsm_state_t state, nxt;
    logic [DW-1:0] a, b;
    logic [4:0] k;
    logic [WDW-1:0] wd;
    logic idle, shifting, acc, expire, ba, bb;
    assign idle = state == IDLE;
    assign shifting = state == START || state == SHIFT;
    assign in_ready = idle && !rst;
    assign acc = in_ready && in_valid;
    assign busy = !idle;
    assign out_valid = state == HOLD;
    assign expire = wd == WDW'(TIMEOUT - 1);
    // While idle the pickers look at the incoming operands so bit 0 is ready at the accepting edge
    bsm_bit_select #(.W(DW)) u_sel_a (
        .op(idle ? in_a : a), .width(idle ? in_wa : WA), .index(idle ? 5'd0 : k), .sel(ba)
    );
    bsm_bit_select #(.W(DW)) u_sel_b (
        .op(idle ? in_b : b), .width(idle ? in_wb : WB), .index(idle ? 5'd0 : k), .sel(bb)
    );
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (in_valid) nxt = START;
            START: nxt = SHIFT;
            SHIFT: if (done || expire) nxt = HOLD;
            HOLD:  if (out_ready) nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            a <= '0;
            b <= '0;
            WA <= '0;
            WB <= '0;
            k <= '0;
            wd <= '0;
            start <= 1'b0;
            bitAin <= 1'b0;
            bitBin <= 1'b0;
            out_o <= '0;
            out_err <= 1'b0;
        end else begin
            start <= acc;
            if (acc) begin
                a <= in_a;
                b <= in_b;
                WA <= in_wa;
                WB <= in_wb;
                k <= 5'd1;
                wd <= '0;
            end
            if (acc || shifting) begin
                bitAin <= ba;
                bitBin <= bb;
            end
            if (shifting) k <= k == 5'd31 ? k : k + 5'd1;
            // done takes priority over the watchdog expiring in the same cycle
            if (state == SHIFT) begin
                wd <= wd + WDW'(1);
                if (done) begin
                    out_o <= O;
                    out_err <= 1'b0;
                end else if (expire) begin
                    out_o <= '0;
                    out_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bsm_operand_driver.sv
// tb_bsm_operand_driver: vector table, directed corner sequences and random pairs against a BSM model
module tb_bsm_operand_driver;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic [31:0] in_a = 0, in_b = 0, out_o, O = 0;
    logic [4:0] in_wa = 0, in_wb = 0, WA, WB;
    logic in_ready, start, bitAin, bitBin, out_valid, out_err, busy, done = 0;
    int checks = 0, errors = 0;
    int done_at = 31;
    logic bsm_en = 1;

    typedef struct { logic [31:0] o; logic err; } exp_t;
    typedef struct {
        logic [31:0] a; logic [4:0] wa; logic [31:0] b; logic [4:0] wb;
        int done_at; logic en; logic [31:0] eo; logic ee; int sh;
    } vec_t;
    exp_t q[$];
    vec_t vec[9];

    bsm_operand_driver dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_wa(in_wa), .in_wb(in_wb),
        .start(start), .WA(WA), .WB(WB), .bitAin(bitAin), .bitBin(bitBin),
        .O(O), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_o(out_o), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // BSM model: rebuilds both operands from the serial stream, strobes done done_at cycles after start
    logic [31:0] ra, rb;
    int cyc = 0;
    logic act = 0;
    always @(negedge clk) begin
        done = 1'b0;
        if (rst) act = 0;
        else begin
            if (start) begin act = 1; cyc = 0; end
            if (act) begin
                if (cyc < 32) begin ra[cyc] = bitAin; rb[cyc] = bitBin; end
                if (bsm_en && cyc == done_at) begin done = 1'b1; O = ra * rb; act = 0; end
                cyc++;
            end
        end
    end

    logic prev_start = 0;
    always @(negedge clk) begin
        exp_t e;
        if (start) chk("start_width", prev_start, 0);
        prev_start = start;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result out_o=%0h", out_o);
            end else begin
                e = q.pop_front();
                chk("out_o", out_o, e.o);
                chk("out_err", out_err, e.err);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [4:0] wa, input logic [31:0] b,
                        input logic [4:0] wb, input logic [31:0] eo, input logic ee);
        int n = 0;
        exp_t e;
        @(posedge clk); #1;
        in_a = a; in_b = b; in_wa = wa; in_wb = wb; in_valid = 1;
        while (!in_ready && n < 500) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%0b expected=1", in_ready);
        end else begin
            @(posedge clk);
            e.o = eo;
            e.err = ee;
            q.push_back(e);
            #1;
        end
        in_valid = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int n = 0, sh = 0;
        done_at = v.done_at;
        bsm_en = v.en;
        send(v.a, v.wa, v.b, v.wb, v.eo, v.ee);
        while (!out_valid && n < 300) begin
            if (busy && !start) sh++;
            @(posedge clk); #1;
            n++;
        end
        chk("shift_cycles", sh, v.sh);
        @(posedge clk); #1;
        chk("drained", q.size(), 0);
    endtask

    initial begin
        logic [3:0] ea, eb;
        logic signed [31:0] sa, sb;
        logic [4:0] wa, wb;
        int n;
        vec[0] = '{32'd15, 5'd8, -32'sd7, 5'd15, 31, 1'b1, -32'sd105, 1'b0, 31};
        vec[1] = '{-32'sd3, 5'd4, 32'd5, 5'd4, 31, 1'b1, -32'sd15, 1'b0, 31};
        vec[2] = '{32'hC000_0000, 5'd31, 32'hFFFF_FFFF, 5'd2, 31, 1'b1, 32'h4000_0000, 1'b0, 31};
        vec[3] = '{32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFF, 5'd1, 31, 1'b1, 32'd1, 1'b0, 31};
        vec[4] = '{32'd100, 5'd8, -32'sd50, 5'd7, 64, 1'b1, -32'sd5000, 1'b0, 64};
        vec[5] = '{32'd9, 5'd5, 32'd9, 5'd5, 31, 1'b0, 32'd0, 1'b1, 64};
        vec[6] = '{32'd7, 5'd4, -32'sd8, 5'd4, 65, 1'b1, 32'd0, 1'b1, 64};
        vec[7] = '{32'h105, 5'd8, 32'd3, 5'd3, 31, 1'b1, 32'd15, 1'b0, 31};
        vec[8] = '{32'h7FFF_FFFF, 5'd31, 32'd3, 5'd3, 31, 1'b1, 32'hFFFF_FFFD, 1'b0, 31};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", start, 0);
        chk("rst_bits", {bitAin, bitBin}, 0);
        chk("rst_widths", {WA, WB}, 0);
        chk("rst_out", {out_valid, out_err, busy}, 0);
        chk("rst_out_o", out_o, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        foreach (vec[i]) run_vec(vec[i]);

        // serial bitstream and framing for A=-3/WA=4, B=5/WB=4
        done_at = 31;
        bsm_en = 1;
        ea = 4'b1101;
        eb = 4'b0101;
        send(-32'sd3, 5'd4, 32'd5, 5'd4, -32'sd15, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            chk("stream_start", start, n == 0);
            chk("stream_a", bitAin, n < 4 ? ea[n] : 1'b1);
            chk("stream_b", bitBin, n < 4 ? eb[n] : 1'b0);
            chk("stream_wa", WA, 4);
            @(posedge clk); #1;
            n++;
        end
        chk("stream_len", n, 32);
        @(posedge clk); #1;

        // result held while the consumer stalls
        out_ready = 0;
        send(32'd6, 5'd4, -32'sd5, 5'd4, -32'sd30, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        repeat (10) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_out_o", out_o, -32'sd30);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_start", start, 0);
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("release_in_ready", in_ready, 1);
        chk("stall_drained", q.size(), 0);

        // reset during SHIFT at k=5 discards the transaction
        send(32'd21, 5'd6, 32'd11, 5'd6, 32'd231, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        q.delete();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", start, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_wa", WA, 0);
        rst = 0;
        #1;
        chk("mid_rst_release", in_ready, 1);
        run_vec(vec[0]);

        // random legal pairs back to back
        done_at = 31;
        bsm_en = 1;
        for (int i = 0; i < 200; i++) begin
            wa = 5'($urandom_range(1, 31));
            wb = 5'($urandom_range(1, 31));
            sa = $urandom;
            sb = $urandom;
            sa = sa >>> (32 - int'(wa));
            sb = sb >>> (32 - int'(wb));
            send(sa, wa, sb, wb, sa * sb, 1'b0);
        end
        n = 0;
        while (q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
        chk("random_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
